// File: rtl/play_receiver_fd_pkg.sv
// play_receiver_fd_pkg: ASCII codes, FSM encodings and frame layout shared by the play-report receiver.
package play_receiver_fd_pkg;

    localparam logic [6:0] ASCII_HASH = 7'h23;
    localparam logic [6:0] ASCII_CIF  = 7'h24;
    localparam logic [6:0] ASCII_0    = 7'h30;
    localparam logic [6:0] ASCII_3    = 7'h33;
    localparam logic [6:0] ASCII_J    = 7'h4A;
    localparam logic [6:0] ASCII_Z    = 7'h5A;
    localparam logic [6:0] ASCII_Y    = 7'h59;
    localparam logic [6:0] ASCII_R    = 7'h52;
    localparam logic [6:0] ASCII_L    = 7'h4C;
    localparam logic [6:0] ASCII_A    = 7'h41;
    localparam logic [6:0] ASCII_B    = 7'h42;
    localparam logic [6:0] ASCII_C    = 7'h43;
    localparam logic [6:0] ASCII_D    = 7'h44;

    localparam int FRAME_BOTAO = 21;
    localparam int FRAME_CIF   = 14;
    localparam int FRAME_POS   = 7;
    localparam int FRAME_HASH  = 0;

    typedef enum logic [1:0] {ESPERA_BOTAO, ESPERA_CIF, ESPERA_POS, ESPERA_HASH} frame_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    function automatic logic [8:0] letter_onehot(input logic [6:0] c);
        logic [8:0] oh;
        oh = 9'b0;
        case (c)
            ASCII_J: oh[0] = 1'b1;
            ASCII_Z: oh[1] = 1'b1;
            ASCII_Y: oh[2] = 1'b1;
            ASCII_R: oh[3] = 1'b1;
            ASCII_L: oh[4] = 1'b1;
            ASCII_A: oh[5] = 1'b1;
            ASCII_B: oh[6] = 1'b1;
            ASCII_C: oh[7] = 1'b1;
            ASCII_D: oh[8] = 1'b1;
            default: oh = 9'b0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/play_receiver_fd_rx.sv
// rx_serial_7E1: 7E1 UART character receiver, strobes char_ok/char_bad at the stop-bit mid-sample.
module rx_serial_7E1
    import play_receiver_fd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zera,
    input  logic       rx,
    output logic [6:0] dados_ascii,
    output logic       char_ok,
    output logic       char_bad,
    output logic       ocupado
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t       st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      sh_q, sh_d, dados_q, dados_d;
    logic            par_q, par_d, ok_q, ok_d, bad_q, bad_d;
    logic            bit_end;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else if (zera) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            dados_q <= '0;
            ok_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else if (zera) begin
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            dados_q <= '0;
            ok_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            dados_q <= dados_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
        end
    end

    assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        dados_d = dados_q;
        ok_d    = 1'b0;
        bad_d   = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s2_q && rx_s3_q) st_d = RX_START;
            end
            RX_START: if (cnt_q == CW'(HALF - 1)) begin
                cnt_d = '0;
                idx_d = '0;
                st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (bit_end) begin
                cnt_d = '0;
                sh_d  = {rx_s2_q, sh_q[6:1]};
                idx_d = idx_q + 1'b1;
                if (idx_q == 3'd6) st_d = RX_PAR;
            end
            RX_PAR: if (bit_end) begin
                cnt_d = '0;
                par_d = rx_s2_q;
                st_d  = RX_STOP;
            end
            RX_STOP: if (bit_end) begin
                // even parity: data plus parity bit must XOR to zero
                cnt_d   = '0;
                st_d    = RX_IDLE;
                dados_d = sh_q;
                ok_d    = rx_s2_q && !(^{sh_q, par_q});
                bad_d   = !(rx_s2_q && !(^{sh_q, par_q}));
            end
            default: st_d = RX_IDLE;
        endcase
    end

    assign dados_ascii = dados_q;
    assign char_ok     = ok_q;
    assign char_bad    = bad_q;
    assign ocupado     = st_q != RX_IDLE;

endmodule

// File: rtl/play_receiver_fd.sv
// play_receiver_fd: parses "<letter>$<digit>#" play frames from the 7E1 link into frame/cmd/pos.
module play_receiver_fd
    import play_receiver_fd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        rx,
    output logic [27:0] frame,
    output logic [8:0]  cmd,
    output logic [1:0]  pos,
    output logic        pronto,
    output logic        erro,
    output logic        recebendo
);

    localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW    = $clog2(LIMIT + 1);

    logic [6:0]   ch;
    logic         ch_ok, ch_bad, ocupado, is_letter, is_pos;
    frame_state_t st_q, st_d;
    logic [6:0]   botao_q, botao_d, posc_q, posc_d;
    logic [27:0]  frame_q, frame_d;
    logic [8:0]   cmd_q, cmd_d;
    logic [1:0]   pos_q, pos_d;
    logic         pronto_q, pronto_d, erro_q, erro_d;
    logic [TW-1:0] tmo_q, tmo_d;

    rx_serial_7E1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .zera       (zera),
        .rx         (rx),
        .dados_ascii(ch),
        .char_ok    (ch_ok),
        .char_bad   (ch_bad),
        .ocupado    (ocupado)
    );

    assign is_letter = |letter_onehot(ch);
    assign is_pos    = ch >= ASCII_0 && ch <= ASCII_3;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q     <= ESPERA_BOTAO;
            botao_q  <= '0;
            posc_q   <= '0;
            frame_q  <= '0;
            cmd_q    <= '0;
            pos_q    <= '0;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
            tmo_q    <= '0;
        end else if (zera) begin
            st_q     <= ESPERA_BOTAO;
            botao_q  <= '0;
            posc_q   <= '0;
            frame_q  <= '0;
            cmd_q    <= '0;
            pos_q    <= '0;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            st_q     <= st_d;
            botao_q  <= botao_d;
            posc_q   <= posc_d;
            frame_q  <= frame_d;
            cmd_q    <= cmd_d;
            pos_q    <= pos_d;
            pronto_q <= pronto_d;
            erro_q   <= erro_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        botao_d  = botao_q;
        posc_d   = posc_q;
        frame_d  = frame_q;
        cmd_d    = cmd_q;
        pos_d    = pos_q;
        pronto_d = 1'b0;
        erro_d   = 1'b0;
        // only idle line time between characters counts towards the timeout
        tmo_d    = (ch_ok || ch_bad || ocupado || st_q == ESPERA_BOTAO) ? '0 :
                   (tmo_q == TW'(LIMIT)) ? tmo_q : tmo_q + 1'b1;
        if (ch_bad) begin
            if (st_q != ESPERA_BOTAO) begin
                erro_d = 1'b1;
                st_d   = ESPERA_BOTAO;
            end
        end else if (ch_ok) begin
            case (st_q)
                ESPERA_BOTAO: if (is_letter) begin
                    botao_d = ch;
                    st_d    = ESPERA_CIF;
                end
                ESPERA_CIF: begin
                    erro_d  = ch != ASCII_CIF;
                    botao_d = is_letter ? ch : botao_q;
                    st_d    = ch == ASCII_CIF ? ESPERA_POS : is_letter ? ESPERA_CIF : ESPERA_BOTAO;
                end
                ESPERA_POS: begin
                    erro_d = !is_pos;
                    posc_d = is_pos ? ch : posc_q;
                    st_d   = is_pos ? ESPERA_HASH : ESPERA_BOTAO;
                end
                ESPERA_HASH: begin
                    st_d = ESPERA_BOTAO;
                    if (ch == ASCII_HASH) begin
                        frame_d[FRAME_BOTAO +: 7] = botao_q;
                        frame_d[FRAME_CIF   +: 7] = ASCII_CIF;
                        frame_d[FRAME_POS   +: 7] = posc_q;
                        frame_d[FRAME_HASH  +: 7] = ASCII_HASH;
                        cmd_d    = letter_onehot(botao_q);
                        pos_d    = posc_q[1:0];
                        pronto_d = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
                default: st_d = ESPERA_BOTAO;
            endcase
        end else if (st_q != ESPERA_BOTAO && tmo_q == TW'(LIMIT)) begin
            erro_d = 1'b1;
            st_d   = ESPERA_BOTAO;
        end
    end

    assign frame     = frame_q;
    assign cmd       = cmd_q;
    assign pos       = pos_q;
    assign pronto    = pronto_q;
    assign erro      = erro_q;
    assign recebendo = st_q != ESPERA_BOTAO;

endmodule

// File: tb/tb_play_receiver_fd.sv
// tb_play_receiver_fd: scoreboard bench driving 7E1 characters into play_receiver_fd.
module tb_play_receiver_fd;

    localparam int CPB = 8;
    localparam int TOB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        zera  = 1'b0;
    logic        rx    = 1'b1;
    logic [27:0] frame;
    logic [8:0]  cmd;
    logic [1:0]  pos;
    logic        pronto, erro, recebendo;

    typedef struct {
        bit          kind;
        logic [27:0] frame;
        logic [8:0]  cmd;
        logic [1:0]  pos;
    } ev_t;

    ev_t         exp_q[$];
    logic [27:0] m_frame = '0;
    logic [8:0]  m_cmd   = '0;
    logic [1:0]  m_pos   = '0;
    int          checks  = 0;
    int          errors  = 0;

    play_receiver_fd #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clock    (clock),
        .reset    (reset),
        .zera     (zera),
        .rx       (rx),
        .frame    (frame),
        .cmd      (cmd),
        .pos      (pos),
        .pronto   (pronto),
        .erro     (erro),
        .recebendo(recebendo)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] model_onehot(input logic [6:0] c);
        string letters = "JZYRLABCD";
        logic [8:0] r = '0;
        for (int i = 0; i < 9; i++) begin
            byte b = letters[i];
            if (b[6:0] == c) r = 9'(1) << i;
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset && (pronto || erro)) begin
            ev_t e;
            checks++;
            if (pronto && erro) begin
                errors++;
                $display("FAIL both_pulses: pronto=%b erro=%b required not both", pronto, erro);
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: pronto=%b erro=%b required no event", pronto, erro);
            end else begin
                e = exp_q.pop_front();
                if (pronto !== e.kind) begin
                    errors++;
                    $display("FAIL event_kind: pronto=%b required %b", pronto, e.kind);
                end
                checks++;
                if (frame !== e.frame || cmd !== e.cmd || pos !== e.pos) begin
                    errors++;
                    $display("FAIL event_outputs: frame=%h cmd=%h pos=%0d required frame=%h cmd=%h pos=%0d",
                             frame, cmd, pos, e.frame, e.cmd, e.pos);
                end
            end
        end
    end

    task automatic send_char(input logic [6:0] c, input bit flip);
        logic [9:0] bits;
        bits = {1'b1, (^c) ^ flip, c, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clock);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte b = s[i];
            send_char(b[6:0], 1'b0);
        end
    endtask

    task automatic expect_pronto(input logic [6:0] c, input logic [6:0] p);
        ev_t e;
        m_frame = {c, 7'h24, p, 7'h23};
        m_cmd   = model_onehot(c);
        m_pos   = p[1:0];
        e = '{1'b1, m_frame, m_cmd, m_pos};
        exp_q.push_back(e);
    endtask

    task automatic expect_erro();
        ev_t e;
        e = '{1'b0, m_frame, m_cmd, m_pos};
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        repeat (20) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_events: pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({frame, cmd, pos, pronto, erro, recebendo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: frame=%h cmd=%h pos=%0d pronto=%b erro=%b recebendo=%b required all 0",
                     frame, cmd, pos, pronto, erro, recebendo);
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_basic();
        expect_pronto(7'h41, 7'h32);
        send_str("A$2#");
        drain("basic");
        checks++;
        if (frame !== 28'h8291923 || cmd !== 9'h020 || pos !== 2'd2) begin
            errors++;
            $display("FAIL basic_frame: frame=%h cmd=%h pos=%0d required 8291923 020 2", frame, cmd, pos);
        end
    endtask

    task automatic test_resync();
        expect_erro();
        expect_pronto(7'h4A, 7'h30);
        send_str("JJ$0#");
        drain("resync");
        checks++;
        if (cmd !== 9'h001 || pos !== 2'd0) begin
            errors++;
            $display("FAIL resync_cmd: cmd=%h pos=%0d required 001 0", cmd, pos);
        end
    endtask

    task automatic test_bad_pos();
        expect_erro();
        send_str("B$7#");
        drain("bad_pos");
        checks++;
        if (frame !== m_frame || cmd !== m_cmd || pos !== m_pos) begin
            errors++;
            $display("FAIL bad_pos_hold: frame=%h cmd=%h required %h %h", frame, cmd, m_frame, m_cmd);
        end
    endtask

    task automatic test_parity();
        expect_erro();
        send_str("C$");
        send_char(7'h31, 1'b1);
        send_str("#");
        drain("parity_bad");
        expect_pronto(7'h43, 7'h31);
        send_str("C$1#");
        drain("parity_good");
        checks++;
        if (pos !== 2'd1 || cmd !== 9'h080) begin
            errors++;
            $display("FAIL parity_good_out: pos=%0d cmd=%h required 1 080", pos, cmd);
        end
    endtask

    task automatic test_timeout();
        expect_erro();
        send_str("D$3");
        checks++;
        if (recebendo !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recebendo_high: recebendo=%b required 1", recebendo);
        end
        repeat (60) @(negedge clock);
        checks++;
        if (recebendo !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recebendo_low: recebendo=%b required 0", recebendo);
        end
        drain("timeout");
        send_str("#");
        drain("timeout_hash");
    endtask

    task automatic test_reset_mid();
        send_str("R$");
        rx = 1'b0;
        repeat (CPB * 3) @(negedge clock);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if ({frame, cmd, pos, pronto, erro, recebendo} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: frame=%h cmd=%h pos=%0d recebendo=%b required all 0",
                     frame, cmd, pos, recebendo);
        end
        m_frame = '0;
        m_cmd   = '0;
        m_pos   = '0;
        reset   = 1'b1;
        drain("reset_mid_quiet");
        expect_pronto(7'h52, 7'h31);
        send_str("R$1#");
        drain("reset_mid_resend");
        checks++;
        if (cmd !== 9'h008) begin
            errors++;
            $display("FAIL reset_mid_cmd: cmd=%h required 008", cmd);
        end
    endtask

    task automatic test_glitch();
        expect_pronto(7'h41, 7'h32);
        send_str("A");
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        rx = 1'b1;
        repeat (16) @(negedge clock);
        checks++;
        if (recebendo !== 1'b1) begin
            errors++;
            $display("FAIL glitch_state: recebendo=%b required 1", recebendo);
        end
        send_str("$2#");
        drain("glitch");
    endtask

    task automatic test_zera();
        send_str("L$");
        zera = 1'b1;
        @(negedge clock);
        zera = 1'b0;
        checks++;
        if (recebendo !== 1'b0 || frame !== '0) begin
            errors++;
            $display("FAIL zera_clear: recebendo=%b frame=%h required 0 0", recebendo, frame);
        end
        m_frame = '0;
        m_cmd   = '0;
        m_pos   = '0;
        send_str("2#");
        drain("zera");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_bad_pos();
        test_parity();
        test_timeout();
        test_reset_mid();
        test_glitch();
        test_zera();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
